// File: rtl/bus_invert_decoder_if.sv
// Handshake bundle for the bus-invert receive decoder: upstream encoded-word
// channel plus downstream decoded-word channel.
interface bus_invert_decoder_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bus_invert_decoder.sv
// Bus-invert link receiver: restores the true word, queues it in a small FIFO
// and keeps a saturating count of words that arrived complemented.
module bus_invert_decoder #(
  parameter int W     = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_invert_decoder_if.slave  bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     inv_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0]    OCC_FULL = OW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [W-1:0] decode(input logic [W-1:0] d, input logic inv);
    return d ^ {W{inv}};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready, out_valid, push, pop;

  // Ready/valid come from stored occupancy only, so a full FIFO refuses a
  // word even when the head is being popped in the same cycle.
  always_comb begin
    in_ready  = (occ_q != OCC_FULL);
    out_valid = (occ_q != '0);
    push      = bus.in_valid && in_ready;
    pop       = out_valid && bus.out_ready;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = decode(bus.in_data, bus.in_inv);
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (push && bus.in_inv) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign inv_count     = cnt_q;
endmodule
